mem_handshake_ctrl: RTL and testbench

- Memory interface between the CPU control logic and the external memory port.
- The control logic issues a one-cycle `start` with `rnw`, plus the address from AR and write data from DR.
- This block latches the request and runs a req/ack handshake with memory, with a timeout.
- It returns a one-cycle `ready` pulse and holds read data for the bus. The control logic stalls its sequence counter until that pulse arrives.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_wait_counter.sv | 31 +++
 rtl/mem_handshake_ctrl.sv | 153 +++++++++++++++
 tb/tb_mem_handshake_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the CPU-to-memory handshake controller.
// The wait-counter compare helper lives here so the counter and any future users agree on it.
package mem_pkg;

    localparam int unsigned ADDR_W_DEF  = 16;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned CMP_W       = CNT_W + 1;

    localparam logic RNW_READ  = 1'b1;
    localparam logic RNW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    // True when one more counted wait cycle brings the count up to the limit.
    function automatic logic next_reaches(input logic [CNT_W-1:0] cnt,
                                          input int unsigned limit);
        return (CMP_W'(cnt) + CMP_W'(1)) >= CMP_W'(limit);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating 8-bit wait counter for the memory request phase.
// hit flags the request cycle in which the count would reach TIMEOUT.
module mem_wait_counter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
)
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [CNT_W-1:0] cnt;

    // Counts request cycles that ended without an ack; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign hit = next_reaches(cnt, TIMEOUT);

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Latches a CPU memory request and runs the req/ack handshake with a timeout,
// returning a one-cycle ready pulse and holding the last successfully read word.
module mem_handshake_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'(ST_IDLE);
    localparam logic [1:0] REQ  = 2'(ST_REQ);
    localparam logic [1:0] DONE = 2'(ST_DONE);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       req_next;
    logic       ready_next;
    logic       err_next;
    logic       overrun_next;
    logic       accept;
    logic       rdata_load;
    logic       cnt_clr;
    logic       cnt_en;
    logic       cnt_hit;

    mem_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .hit (cnt_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the next values of every registered output.
    always_comb begin
        state_next   = state;
        req_next     = 1'b0;
        ready_next   = 1'b0;
        err_next     = 1'b0;
        overrun_next = overrun;
        accept       = 1'b0;
        rdata_load   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = REQ;
                    req_next   = 1'b1;
                end
            end
            REQ: begin
                if (start) begin
                    overrun_next = 1'b1;
                end
                // An ack in the timeout cycle still completes cleanly.
                if (mem_ack) begin
                    state_next = DONE;
                    ready_next = 1'b1;
                    rdata_load = ((~mem_we) == RNW_READ);
                end else if (cnt_hit) begin
                    state_next = DONE;
                    ready_next = 1'b1;
                    err_next   = 1'b1;
                end else begin
                    req_next = 1'b1;
                    cnt_en   = 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = REQ;
                    req_next   = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cnt_clr = accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            mem_req <= req_next;
            ready   <= ready_next;
            err     <= err_next;
            overrun <= overrun_next;
        end
    end

    // Request registers change only when a new access is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (accept) begin
            mem_we    <= (rnw == RNW_WRITE);
            mem_addr  <= addr;
            mem_wdata <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rdata_load) begin
            rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Self-checking bench: three controllers with TIMEOUT 4, 2 and 1, driven by directed
// and randomized accesses and checked against a cycle-count model of the handshake.
`timescale 1ns/1ps
module tb_mem_handshake_ctrl;

    localparam int NDUT = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;

    function automatic int to_of(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 2 : 1);
    endfunction

    logic clk = 1'b0;
    logic rst;

    logic [NDUT-1:0] start, rnw, mem_ack, ready, err, overrun, mem_req, mem_we;
    logic [AW-1:0]   addr      [NDUT];
    logic [AW-1:0]   mem_addr  [NDUT];
    logic [DW-1:0]   wdata     [NDUT];
    logic [DW-1:0]   rdata     [NDUT];
    logic [DW-1:0]   mem_wdata [NDUT];
    logic [DW-1:0]   mem_rdata [NDUT];

    // Reference state: what each controller should currently present.
    logic [DW-1:0]   exp_rdata [NDUT];
    logic            exp_ov    [NDUT];
    logic [AW-1:0]   last_addr [NDUT];
    logic [DW-1:0]   last_wd   [NDUT];
    logic            last_we   [NDUT];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_handshake_ctrl #(
            .ADDR_W  (AW),
            .DATA_W  (DW),
            .TIMEOUT (to_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .rnw       (rnw[g]),
            .addr      (addr[g]),
            .wdata     (wdata[g]),
            .ready     (ready[g]),
            .rdata     (rdata[g]),
            .err       (err[g]),
            .overrun   (overrun[g]),
            .mem_req   (mem_req[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_ack   (mem_ack[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            exp_rdata[g] = '0;
            exp_ov[g]    = 1'b0;
            last_addr[g] = '0;
            last_wd[g]   = '0;
            last_we[g]   = 1'b0;
        end
    endtask

    // One access issued in the current cycle; returns in its ready cycle.
    // j = cycles after the first request cycle at which ack is driven (j >= TIMEOUT: never).
    // ov = request-cycle index at which a stray start is pulsed (-1: none).
    task automatic access(input int d, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] w, input int j,
                          input logic [DW-1:0] word, input int ov);
        int   t;
        int   reqc;
        logic tmo;
        t    = to_of(d);
        reqc = (j < t) ? j + 1 : t;
        tmo  = (j >= t);
        start[d] = 1'b1; rnw[d] = r; addr[d] = a; wdata[d] = w; mem_ack[d] = 1'b0;
        @(posedge clk); #1;
        start[d] = 1'b0;
        for (int n = 0; n < reqc; n++) begin
            tests_run++;
            if (mem_req[d] !== 1'b1 || ready[d] !== 1'b0 || err[d] !== 1'b0)
                begin tests_failed++; $display("FAIL req_phase d%0d n%0d: req=%b ready=%b err=%b want 1 0 0", d, n, mem_req[d], ready[d], err[d]); end
            tests_run++;
            if (mem_addr[d] !== a || mem_wdata[d] !== w || mem_we[d] !== ~r || rdata[d] !== exp_rdata[d])
                begin tests_failed++; $display("FAIL req_stable d%0d n%0d: addr=%h wd=%h we=%b rdata=%h want %h %h %b %h", d, n, mem_addr[d], mem_wdata[d], mem_we[d], rdata[d], a, w, ~r, exp_rdata[d]); end
            mem_ack[d]   = (n == j);
            mem_rdata[d] = (n == j) ? word : DW'($urandom);
            start[d]     = (n == ov);
            if (n == ov) begin
                addr[d] = ~a; wdata[d] = ~w; rnw[d] = ~r; exp_ov[d] = 1'b1;
            end
            @(posedge clk); #1;
        end
        start[d] = 1'b0; mem_ack[d] = 1'b0;
        if (!tmo && r == 1'b1) exp_rdata[d] = word;
        last_addr[d] = a; last_wd[d] = w; last_we[d] = ~r;
        tests_run++;
        if (ready[d] !== 1'b1 || err[d] !== tmo || mem_req[d] !== 1'b0)
            begin tests_failed++; $display("FAIL done d%0d: ready=%b err=%b req=%b want 1 %b 0", d, ready[d], err[d], mem_req[d], tmo); end
        tests_run++;
        if (rdata[d] !== exp_rdata[d] || overrun[d] !== exp_ov[d] || mem_addr[d] !== a)
            begin tests_failed++; $display("FAIL done_data d%0d: rdata=%h ov=%b addr=%h want %h %b %h", d, rdata[d], overrun[d], mem_addr[d], exp_rdata[d], exp_ov[d], a); end
    endtask

    // Quiet cycles with random ack noise that the controller must ignore.
    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ack[d]   = 1'($urandom);
            mem_rdata[d] = DW'($urandom);
            @(posedge clk); #1;
            tests_run++;
            if (ready[d] !== 1'b0 || mem_req[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== exp_rdata[d])
                begin tests_failed++; $display("FAIL idle d%0d i%0d: ready=%b req=%b err=%b rdata=%h want 0 0 0 %h", d, i, ready[d], mem_req[d], err[d], rdata[d], exp_rdata[d]); end
            tests_run++;
            if (mem_addr[d] !== last_addr[d] || mem_wdata[d] !== last_wd[d] || mem_we[d] !== last_we[d] || overrun[d] !== exp_ov[d])
                begin tests_failed++; $display("FAIL idle_hold d%0d i%0d: addr=%h wd=%h we=%b ov=%b want %h %h %b %b", d, i, mem_addr[d], mem_wdata[d], mem_we[d], overrun[d], last_addr[d], last_wd[d], last_we[d], exp_ov[d]); end
        end
        mem_ack[d] = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        for (int g = 0; g < NDUT; g++) begin
            tests_run++;
            if (ready[g] !== 1'b0 || err[g] !== 1'b0 || overrun[g] !== 1'b0 || mem_req[g] !== 1'b0 ||
                mem_we[g] !== 1'b0 || mem_addr[g] !== '0 || mem_wdata[g] !== '0 || rdata[g] !== '0)
                begin tests_failed++; $display("FAIL %s d%0d: ready=%b err=%b ov=%b req=%b we=%b addr=%h wd=%h rdata=%h want all zero", tag, g, ready[g], err[g], overrun[g], mem_req[g], mem_we[g], mem_addr[g], mem_wdata[g], rdata[g]); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset_values");
        rst = 1'b0;
        idle(0, 2);
    endtask

    task automatic test_read_ack0();
        access(0, 1'b1, 16'h0040, 16'h7777, 0, 16'hBEEF, -1);
        idle(0, 2);
    endtask

    task automatic test_write_ack3();
        access(0, 1'b0, 16'h1234, 16'h00FF, 3, 16'hDEAD, -1);
        idle(0, 2);
    endtask

    task automatic test_timeout();
        access(0, 1'b1, 16'h2222, 16'h3333, 50, 16'hCAFE, -1);
        idle(0, 2);
    endtask

    task automatic test_overrun_back_to_back();
        access(0, 1'b1, 16'hA5A5, 16'h0101, 2, 16'h1357, 1);
        access(0, 1'b0, 16'h5A5A, 16'h0202, 0, 16'h0000, -1);
        access(0, 1'b1, 16'h0F0F, 16'h0303, 1, 16'h2468, -1);
        idle(0, 3);
    endtask

    task automatic test_boundary();
        access(1, 1'b1, 16'h0100, 16'h0000, 1, 16'h4242, -1);
        idle(1, 1);
        access(1, 1'b1, 16'h0101, 16'h0000, 2, 16'h9999, -1);
        idle(1, 1);
        access(2, 1'b1, 16'h0200, 16'h0000, 7, 16'h8888, -1);
        idle(2, 1);
        access(2, 1'b1, 16'h0201, 16'h0000, 0, 16'h6161, -1);
        idle(2, 1);
    endtask

    task automatic test_reset_mid_access();
        start[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 16'hF00D; wdata[0] = 16'h1111; mem_ack[0] = 1'b0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (mem_req[0] !== 1'b1)
            begin tests_failed++; $display("FAIL pre_reset_req: got %b want 1", mem_req[0]); end
        #2 rst = 1'b1;
        #1;
        check_reset_values("reset_async");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int g = 0; g < NDUT; g++) idle(g, 3);
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int d, t, j, reqc, ov, gap;
            d    = int'($urandom_range(0, NDUT - 1));
            t    = to_of(d);
            j    = int'($urandom_range(0, t + 2));
            reqc = (j < t) ? j + 1 : t;
            ov   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, reqc - 1)) : -1;
            gap  = int'($urandom_range(0, 2));
            access(d, 1'($urandom), AW'($urandom), DW'($urandom), j, DW'($urandom), ov);
            if (gap != 0) idle(d, gap);
        end
        for (int g = 0; g < NDUT; g++) idle(g, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = '0; rnw = '0; mem_ack = '0;
        for (int g = 0; g < NDUT; g++) begin
            addr[g] = '0; wdata[g] = '0; mem_rdata[g] = '0;
        end
        model_reset();

        test_reset();
        test_read_ack0();
        test_write_ack3();
        test_timeout();
        test_overrun_back_to_back();
        test_boundary();
        test_reset_mid_access();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
